// File: rtl/fetch_sequencer.sv
// Fetch sequencer: walks the byte-addressed program counter through four byte reads,
// assembles a 32-bit instruction, offers it to decode and then issues one advance/jump/branch strobe.
module fetch_sequencer #(
   parameter bit BIG_ENDIAN = 1'b1,
   parameter int COUNT_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   input  logic [7:0]         mem_data,
   output logic [31:0]        instr,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               take_jump,
   input  logic               take_branch,
   input  logic [5:0]         target,
   output logic               update_lsbs,
   output logic               update_msbs,
   output logic               jump,
   output logic [5:0]         jump_destination,
   output logic               branch,
   output logic [5:0]         branch_offset,
   output logic [COUNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_B0   = 3'd0,
      S_B1   = 3'd1,
      S_B2   = 3'd2,
      S_B3   = 3'd3,
      S_PRES = 3'd4,
      S_ADV  = 3'd5
   } state_t;

   state_t             r_state;
   logic [31:0]        r_instr;
   logic               r_instr_valid;
   logic               r_update_msbs;
   logic               r_jump;
   logic               r_branch;
   logic [5:0]         r_jump_destination;
   logic [5:0]         r_branch_offset;
   logic [COUNT_W-1:0] r_retired;
   logic               w_update_lsbs;

   function automatic logic [31:0] put_byte(input logic [31:0] cur, input int slot,
                                            input logic [7:0] b);
      logic [31:0] res;
      int          pos;
      res = cur;
      pos = BIG_ENDIAN ? 8 * (3 - slot) : 8 * slot;
      res[pos +: 8] = b;
      return res;
   endfunction

   // The B0 step is gated by run in the same cycle so an idle sequencer never moves the counter.
   always_comb begin
      w_update_lsbs = 1'b0;
      case (r_state)
         S_B0:    w_update_lsbs = run;
         S_B1:    w_update_lsbs = 1'b1;
         S_B2:    w_update_lsbs = 1'b1;
         default: w_update_lsbs = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state            <= S_B0;
         r_instr            <= '0;
         r_instr_valid      <= 1'b0;
         r_update_msbs      <= 1'b0;
         r_jump             <= 1'b0;
         r_branch           <= 1'b0;
         r_jump_destination <= '0;
         r_branch_offset    <= '0;
         r_retired          <= '0;
      end else begin
         r_update_msbs <= 1'b0;
         r_jump        <= 1'b0;
         r_branch      <= 1'b0;
         case (r_state)
            S_B0: begin
               if (run) begin
                  r_instr <= put_byte(r_instr, 0, mem_data);
                  r_state <= S_B1;
               end
            end
            S_B1: begin
               r_instr <= put_byte(r_instr, 1, mem_data);
               r_state <= S_B2;
            end
            S_B2: begin
               r_instr <= put_byte(r_instr, 2, mem_data);
               r_state <= S_B3;
            end
            S_B3: begin
               r_instr       <= put_byte(r_instr, 3, mem_data);
               r_instr_valid <= 1'b1;
               r_state       <= S_PRES;
            end
            S_PRES: begin
               // Strobes are registered here so exactly one is high for the whole ADV cycle.
               if (instr_ready) begin
                  r_instr_valid      <= 1'b0;
                  r_jump_destination <= target;
                  r_branch_offset    <= target;
                  r_retired          <= r_retired + COUNT_W'(1);
                  r_jump             <= take_jump;
                  r_branch           <= take_branch & ~take_jump;
                  r_update_msbs      <= ~take_jump & ~take_branch;
                  r_state            <= S_ADV;
               end
            end
            S_ADV: begin
               r_state <= S_B0;
            end
            default: begin
               r_state <= S_B0;
            end
         endcase
      end
   end

   assign instr            = r_instr;
   assign instr_valid      = r_instr_valid;
   assign update_lsbs      = w_update_lsbs;
   assign update_msbs      = r_update_msbs;
   assign jump             = r_jump;
   assign branch           = r_branch;
   assign jump_destination = r_jump_destination;
   assign branch_offset    = r_branch_offset;
   assign retired          = r_retired;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a program-counter and memory environment plus an
// instruction-level reference model; big- and little-endian instances run side by side.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst, run, instr_ready, take_jump, take_branch;
   logic [5:0]  target;
   logic [7:0]  mem_data;

   logic [31:0] instr_b, instr_l;
   logic        vld_b, vld_l, lsb_b, lsb_l, msb_b, msb_l, jmp_b, jmp_l, br_b, br_l;
   logic [5:0]  jd_b, jd_l, bo_b, bo_l;
   logic [15:0] ret_b, ret_l;

   always #5 clk = ~clk;

   fetch_sequencer #(.BIG_ENDIAN(1'b1), .COUNT_W(16)) dut_be (
      .clk(clk), .rst(rst), .run(run), .mem_data(mem_data),
      .instr(instr_b), .instr_valid(vld_b), .instr_ready(instr_ready),
      .take_jump(take_jump), .take_branch(take_branch), .target(target),
      .update_lsbs(lsb_b), .update_msbs(msb_b), .jump(jmp_b),
      .jump_destination(jd_b), .branch(br_b), .branch_offset(bo_b), .retired(ret_b)
   );

   fetch_sequencer #(.BIG_ENDIAN(1'b0), .COUNT_W(16)) dut_le (
      .clk(clk), .rst(rst), .run(run), .mem_data(mem_data),
      .instr(instr_l), .instr_valid(vld_l), .instr_ready(instr_ready),
      .take_jump(take_jump), .take_branch(take_branch), .target(target),
      .update_lsbs(lsb_l), .update_msbs(msb_l), .jump(jmp_l),
      .jump_destination(jd_l), .branch(br_l), .branch_offset(bo_l), .retired(ret_l)
   );

   // Environment: instruction memory and the byte-addressed counter driven by the strobes.
   logic [7:0] mem [256];
   logic [7:0] pc;
   assign mem_data = mem[pc];

   always @(posedge clk) begin
      if (rst)        pc <= 8'h00;
      else if (jmp_b) pc <= {jd_b, 2'b00};
      else if (br_b)  pc <= {pc[7:2] + bo_b, 2'b00};
      else if (msb_b) pc <= {pc[7:2] + 6'd1, 2'b00};
      else if (lsb_b) pc <= pc + 8'd1;
   end

   // Reference model: current instruction index and retired count.
   logic [5:0]  m_idx;
   logic [15:0] m_ret;
   int          n_chk = 0;
   int          n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [31:0] exp_instr(input bit be);
      logic [7:0] b0, b1, b2, b3;
      b0 = mem[{m_idx, 2'd0}];
      b1 = mem[{m_idx, 2'd1}];
      b2 = mem[{m_idx, 2'd2}];
      b3 = mem[{m_idx, 2'd3}];
      return be ? {b0, b1, b2, b3} : {b3, b2, b1, b0};
   endfunction

   function automatic logic [3:0] stb_b();
      return {lsb_b, msb_b, jmp_b, br_b};
   endfunction

   function automatic logic [3:0] stb_l();
      return {lsb_l, msb_l, jmp_l, br_l};
   endfunction

   task automatic garbage_ctl();
      take_jump   = 1'($urandom);
      take_branch = 1'($urandom);
      target      = 6'($urandom);
   endtask

   // One full instruction: optional idle in B0, fetch, optional decode stall, handshake, advance.
   task automatic do_instr(input int idle, input int delay, input bit tj, input bit tbr,
                           input logic [5:0] tgt);
      logic [31:0] hold;
      logic [3:0]  exp_stb;
      int          n, lsbs, other;
      if (idle > 0) begin
         run = 1'b0;
         #1;
         repeat (idle) begin
            chk("idle_strobe", 32'(stb_b()), 32'h0);
            chk("idle_valid", 32'(vld_b), 32'h0);
            @(posedge clk); #1;
         end
         run = 1'b1;
         #1;
      end
      chk("fetch_pc", 32'(pc), 32'({m_idx, 2'b00}));
      n = 0; lsbs = 0; other = 0;
      while (!vld_b && n < 20) begin
         lsbs  += int'(lsb_b);
         other += int'(msb_b | jmp_b | br_b);
         instr_ready = 1'($urandom);
         garbage_ctl();
         @(posedge clk); #1;
         n++;
      end
      chk("fetch_cycles", 32'(n), 32'd4);
      chk("lsb_pulses", 32'(lsbs), 32'd3);
      chk("fetch_other_strobe", 32'(other), 32'd0);
      chk("instr_be", instr_b, exp_instr(1'b1));
      chk("instr_le", instr_l, exp_instr(1'b0));
      chk("pres_strobe", 32'(stb_b()), 32'h0);
      hold = instr_b;
      repeat (delay) begin
         instr_ready = 1'b0;
         garbage_ctl();
         @(posedge clk); #1;
         chk("stall_valid", 32'(vld_b), 32'h1);
         chk("stall_instr", instr_b, hold);
         chk("stall_strobe", 32'(stb_b()), 32'h0);
         chk("stall_retired", 32'(ret_b), 32'(m_ret));
      end
      instr_ready = 1'b1;
      take_jump   = tj;
      take_branch = tbr;
      target      = tgt;
      @(posedge clk); #1;
      instr_ready = 1'($urandom);
      garbage_ctl();
      run = 1'($urandom);
      m_ret   = m_ret + 16'd1;
      exp_stb = tj ? 4'b0010 : (tbr ? 4'b0001 : 4'b0100);
      chk("adv_strobe_be", 32'(stb_b()), 32'(exp_stb));
      chk("adv_strobe_le", 32'(stb_l()), 32'(exp_stb));
      chk("adv_jump_dest", 32'(jd_b), 32'(tgt));
      chk("adv_branch_off", 32'(bo_b), 32'(tgt));
      chk("adv_retired_be", 32'(ret_b), 32'(m_ret));
      chk("adv_retired_le", 32'(ret_l), 32'(m_ret));
      chk("adv_valid", 32'({vld_b, vld_l}), 32'h0);
      chk("adv_le_targets", 32'({jd_l, bo_l}), 32'({tgt, tgt}));
      if (tj)       m_idx = tgt;
      else if (tbr) m_idx = m_idx + tgt;
      else          m_idx = m_idx + 6'd1;
      @(posedge clk); #1;
      run = 1'b1;
      #1;
      chk("next_pc", 32'(pc), 32'({m_idx, 2'b00}));
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
      rst = 1'b1; run = 1'b0; instr_ready = 1'b0;
      take_jump = 1'b0; take_branch = 1'b0; target = 6'h00;
      m_idx = 6'd0; m_ret = 16'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'({vld_b, vld_l}), 32'h0);
      chk("rst_instr", instr_b, 32'h0);
      chk("rst_strobe", 32'(stb_b()), 32'h0);
      chk("rst_targets", 32'({jd_b, bo_b}), 32'h0);
      chk("rst_retired", 32'(ret_b), 32'h0);
      rst = 1'b0;
      run = 1'b1;
      #1;

      do_instr(0, 0, 1'b0, 1'b0, 6'h00);
      chk("first_instr_be_const", instr_b, 32'h12345678);
      chk("first_instr_le_const", instr_l, 32'h78563412);
      do_instr(0, 10, 1'b1, 1'b1, 6'h05);
      do_instr(2, 0, 1'b0, 1'b0, 6'h00);
      do_instr(0, 0, 1'b1, 1'b0, 6'h04);
      do_instr(0, 0, 1'b0, 1'b1, 6'h3F);
      do_instr(0, 1, 1'b1, 1'b0, 6'h3F);
      do_instr(0, 0, 1'b0, 1'b0, 6'h11);
      for (int k = 0; k < 40; k++)
         do_instr($urandom_range(0, 2), $urandom_range(0, 3),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 6'($urandom));
      do_instr(0, 0, 1'b0, 1'b0, 6'h2A);

      // Reset in the middle of a fetch, then hold run low.
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("b2_lsb", 32'(lsb_b), 32'h1);
      rst = 1'b1;
      run = 1'b0;
      @(posedge clk); #1;
      chk("midrst_valid", 32'(vld_b), 32'h0);
      chk("midrst_strobe", 32'(stb_b()), 32'h0);
      chk("midrst_retired", 32'(ret_b), 32'h0);
      chk("midrst_targets", 32'({jd_b, bo_b}), 32'h0);
      chk("midrst_instr", instr_b, 32'h0);
      rst = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         chk("run_low_lsb", 32'(lsb_b), 32'h0);
         chk("run_low_valid", 32'(vld_b), 32'h0);
      end
      m_idx = 6'd0;
      m_ret = 16'd0;
      run = 1'b1;
      #1;
      do_instr(0, 0, 1'b0, 1'b0, 6'h00);
      do_instr(1, 2, 1'b0, 1'b1, 6'h02);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
